mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute unit. Holds the EX/MEM and MEM/WB pipeline registers and drives a ready/valid data-memory port with a bounded-wait watchdog. It supplies the EX forwarding and load-hazard inputs (ALUouttoMe, rwtoMe, RegWrtoMe, MentoRegtoMe, busW, rwtoRe, RegWrtoRe). It stalls upstream stages while a memory access is outstanding.

## Interface
- TIMEOUT, 16: max cycles a request may wait for dm_ready before abort (≥2)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ALUout  in  32  EX result / effective address
- ex_busB  in  32  forwarded rt value (store data)
- ex_rw  in  5  destination register
- ex_RegWr, ex_MemtoReg, ex_MemWr  in  1 each  control from EX
- ex_size  in  2  00 word, 01 half, 10 byte (MEM_BYTE_EN only)
- ex_sext  in  1  sign-extend sub-word load (MEM_BYTE_EN only)
- ALUouttoMe  out  32; rwtoMe  out  5; RegWrtoMe, MentoRegtoMe  out  1: EX/MEM contents
- busW  out  32; rwtoRe  out  5; RegWrtoRe  out  1: MEM/WB contents
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- dm_req, dm_we  out  1; dm_addr, dm_wdata  out  32; dm_be  out  4
- dm_ready  in  1; dm_rdata  in  32
- err_align, err_bus  out  1  one-cycle error flags aligned with MEM/WB

## Operation
- EX/MEM loads on each clk when mem_stall=0. Captures ex_valid and all ex_* fields. ALUout is stored as exm_addr.
- memop = exm_valid & (MentoRegtoMe | exm_MemWr). A load has MentoRegtoMe=1.
- Misaligned: word access with addr[1:0]≠0, or half access with addr[0]≠0. A misaligned access issues no request and completes immediately. It raises err_align, and RegWr is suppressed.
- FSM states:
  - IDLE: dm_req = memop & aligned. If dm_ready is sampled high in the same cycle, the access completes (zero-wait). Otherwise go to WAIT and clear cnt.
  - WAIT: dm_req=1, with addr, wdata, be and we held stable. cnt increments each cycle.
    - dm_ready=1: complete and return to IDLE.
    - cnt = TIMEOUT-1 without ready: abort, raise err_bus, suppress RegWr, return to IDLE.
- mem_stall = dm_req & ~dm_ready & ~abort. It is combinational and must not depend on ex_* inputs.
- MEM/WB loads when mem_stall=0:
  - busW = load ? formatted dm_rdata : exm_addr
  - RegWrtoRe = exm_valid & RegWr & ~err
  - on a bubble, RegWrtoRe=0
- dm_we = exm_MemWr. dm_addr = {exm_addr[31:2],2'b00}. Word stores use dm_be = 4'b1111.

## Timing
- Reset (asynchronous): every register is 0, the state is IDLE, and cnt is 0. As a result, all outputs are 0 and mem_stall=0.
- Reset asserted mid-access: the request is dropped immediately and dm_req goes low asynchronously.
- Non-memory instruction: 1 cycle in EX/MEM, then 1 cycle in MEM/WB.
- Memory access with N wait cycles stalls N cycles. A zero-wait access stalls 0 cycles. Worst case is TIMEOUT cycles.
- While stalled, both pipeline registers hold and busW/rwtoRe/RegWrtoRe stay stable. This keeps WB forwarding valid.
- err_* flags are high for exactly one cycle: the cycle their instruction occupies MEM/WB.

## Configuration
- MEM_BYTE_EN defined: half and byte accesses are supported.
  - Stores replicate the datum across lanes and drive dm_be from addr[1:0].
  - Loads select the lane and zero- or sign-extend per ex_sext.
  - ex_size and ex_sext are used.
- MEM_BYTE_EN undefined: word-only. ex_size and ex_sext are ignored, dm_be is always 4'b1111, and only word misalignment is checked.

## Structure
- Shared package mem_pkg holds:
  - state enum (ST_IDLE, ST_WAIT)
  - size codes (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10)
  - lane-mask constants
- One sub-module, mem_align:
  - combinational
  - produces dm_be, replicated wdata, the misaligned flag, and load data extraction/extension
  - byte/half logic is inside `ifdef MEM_BYTE_EN

## Test plan
- add result 0x0000_1234 to rw=5 -> two cycles later busW=0x1234, rwtoRe=5, RegWrtoRe=1, mem_stall never high.
- lw addr 0x100, dm_ready after 3 cycles with rdata 0xDEADBEEF -> mem_stall high exactly 3 cycles, then busW=0xDEADBEEF and RegWrtoRe=1.
- sw addr 0x204, data 0x55AA, dm_ready same cycle -> dm_we=1, dm_be=4'hF, dm_addr=0x204, no stall.
- lw addr 0x102 -> dm_req never asserted, err_align=1 for one cycle, RegWrtoRe=0.
- lw, dm_ready held low, TIMEOUT=16 -> mem_stall for 16 cycles, err_bus=1, RegWrtoRe=0, FSM returns to IDLE, next instruction proceeds.
- MEM_BYTE_EN: lb addr 0x103, rdata 0x80xxxxxx, ex_sext=1 -> busW=0xFFFF_FF80. Also: rst_n low while in WAIT -> dm_req=0 at once and all outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage: FSM states, access
// size codes and byte-lane masks.
package mem_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_align.sv
// Lane steering for data-memory accesses: byte enables, store replication,
// misalignment detection and load extraction. Sub-word support under MEM_BYTE_EN.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata_fmt
);

`ifdef MEM_BYTE_EN
  logic [15:0] lane16;
  logic [7:0]  lane8;

  always_comb begin
    be        = BE_WORD;
    wdata_rep = wdata;
    misalign  = |addr;
    rdata_fmt = rdata;
    lane16    = '0;
    lane8     = '0;
    case (size)
      SZ_HALF: begin
        be        = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr[0];
        lane16    = addr[1] ? rdata[31:16] : rdata[15:0];
        rdata_fmt = {{16{sext & lane16[15]}}, lane16};
      end
      SZ_BYTE: begin
        be        = BE_BYTE0 << addr;
        wdata_rep = {4{wdata[7:0]}};
        misalign  = 1'b0;
        lane8     = rdata[{addr, 3'b000} +: 8];
        rdata_fmt = {{24{sext & lane8[7]}}, lane8};
      end
      default: ;
    endcase
  end
`else
  logic unused_cfg;

  assign be         = BE_WORD;
  assign wdata_rep  = wdata;
  assign misalign   = |addr;
  assign rdata_fmt  = rdata;
  assign unused_cfg = ^{size, sext};
`endif

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM and MEM/WB registers plus a ready/valid data-memory
// port with timeout abort. Optional sub-word accesses under MEM_BYTE_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ALUout,
  input  logic [31:0] ex_busB,
  input  logic [4:0]  ex_rw,
  input  logic        ex_RegWr,
  input  logic        ex_MemtoReg,
  input  logic        ex_MemWr,
  input  logic [1:0]  ex_size,
  input  logic        ex_sext,
  output logic [31:0] ALUouttoMe,
  output logic [4:0]  rwtoMe,
  output logic        RegWrtoMe,
  output logic        MentoRegtoMe,
  output logic [31:0] busW,
  output logic [4:0]  rwtoRe,
  output logic        RegWrtoRe,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        err_align,
  output logic        err_bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          exm_valid;
  logic [31:0]   exm_addr;
  logic [31:0]   exm_wdata;
  logic [4:0]    exm_rw;
  logic          exm_RegWr;
  logic          exm_MemtoReg;
  logic          exm_MemWr;
  logic [1:0]    exm_size;
  logic          exm_sext;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          memop, misalign, abort, err_a;
  logic [31:0]   rdata_fmt;

  mem_align u_align (
    .addr      (exm_addr[1:0]),
    .size      (exm_size),
    .sext      (exm_sext),
    .wdata     (exm_wdata),
    .rdata     (dm_rdata),
    .be        (dm_be),
    .wdata_rep (dm_wdata),
    .misalign  (misalign),
    .rdata_fmt (rdata_fmt)
  );

  assign memop     = exm_valid & (exm_MemtoReg | exm_MemWr);
  assign err_a     = memop & misalign;
  assign mem_stall = dm_req & ~dm_ready & ~abort;

  assign dm_we   = exm_MemWr;
  assign dm_addr = {exm_addr[31:2], 2'b00};

  assign ALUouttoMe   = exm_addr;
  assign rwtoMe       = exm_rw;
  assign RegWrtoMe    = exm_RegWr;
  assign MentoRegtoMe = exm_MemtoReg;

  // dm_req derives only from registered state, so reset drops it asynchronously.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dm_req   = 1'b0;
    abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        dm_req = memop & ~misalign;
        if (dm_req && !dm_ready) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
        end
      end
      ST_WAIT: begin
        dm_req = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (dm_ready) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          abort    = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid    <= 1'b0;
      exm_addr     <= '0;
      exm_wdata    <= '0;
      exm_rw       <= '0;
      exm_RegWr    <= 1'b0;
      exm_MemtoReg <= 1'b0;
      exm_MemWr    <= 1'b0;
      exm_size     <= SZ_WORD;
      exm_sext     <= 1'b0;
    end else if (!mem_stall) begin
      exm_valid    <= ex_valid;
      exm_addr     <= ALUout;
      exm_wdata    <= ex_busB;
      exm_rw       <= ex_rw;
      exm_RegWr    <= ex_RegWr;
      exm_MemtoReg <= ex_MemtoReg;
      exm_MemWr    <= ex_MemWr;
      exm_size     <= ex_size;
      exm_sext     <= ex_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busW      <= '0;
      rwtoRe    <= '0;
      RegWrtoRe <= 1'b0;
      err_align <= 1'b0;
      err_bus   <= 1'b0;
    end else if (!mem_stall) begin
      busW      <= exm_MemtoReg ? rdata_fmt : exm_addr;
      rwtoRe    <= exm_rw;
      RegWrtoRe <= exm_valid & exm_RegWr & ~err_a & ~abort;
      err_align <= err_a;
      err_bus   <= abort;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads/stores with
// wait states, misalignment, timeout abort, sub-word load and reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ALUout;
  logic [31:0] ex_busB;
  logic [4:0]  ex_rw;
  logic        ex_RegWr;
  logic        ex_MemtoReg;
  logic        ex_MemWr;
  logic [1:0]  ex_size;
  logic        ex_sext;
  logic [31:0] ALUouttoMe;
  logic [4:0]  rwtoMe;
  logic        RegWrtoMe;
  logic        MentoRegtoMe;
  logic [31:0] busW;
  logic [4:0]  rwtoRe;
  logic        RegWrtoRe;
  logic        mem_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        err_align;
  logic        err_bus;

  int total = 0;
  int bad   = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ALUout       (ALUout),
    .ex_busB      (ex_busB),
    .ex_rw        (ex_rw),
    .ex_RegWr     (ex_RegWr),
    .ex_MemtoReg  (ex_MemtoReg),
    .ex_MemWr     (ex_MemWr),
    .ex_size      (ex_size),
    .ex_sext      (ex_sext),
    .ALUouttoMe   (ALUouttoMe),
    .rwtoMe       (rwtoMe),
    .RegWrtoMe    (RegWrtoMe),
    .MentoRegtoMe (MentoRegtoMe),
    .busW         (busW),
    .rwtoRe       (rwtoRe),
    .RegWrtoRe    (RegWrtoRe),
    .mem_stall    (mem_stall),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_be        (dm_be),
    .dm_ready     (dm_ready),
    .dm_rdata     (dm_rdata),
    .err_align    (err_align),
    .err_bus      (err_bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ex_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rw, input logic rwr, input logic m2r,
                       input logic mw, input logic [1:0] sz, input logic sx);
    ex_valid    = v;
    ALUout      = a;
    ex_busB     = b;
    ex_rw       = rw;
    ex_RegWr    = rwr;
    ex_MemtoReg = m2r;
    ex_MemWr    = mw;
    ex_size     = sz;
    ex_sext     = sx;
  endtask

  task automatic bubble();
    ex_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Called just after the edge that loads a memory op into EX/MEM; returns
  // after the completing edge (+1) with the number of stalled cycles seen.
  task automatic mem_access(input int waits, input logic [31:0] rdata, output int n);
    n        = 0;
    dm_rdata = rdata;
    dm_ready = (waits == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall) break;
      n++;
      if (n == waits) begin
        dm_ready = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    dm_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    bubble();

    @(negedge clk);
    check_eq("rst_busW", busW, 32'h0);
    check_eq("rst_regwr_re", {31'b0, RegWrtoRe}, 32'h0);
    check_eq("rst_dm_req", {31'b0, dm_req}, 32'h0);
    check_eq("rst_stall", {31'b0, mem_stall}, 32'h0);
    check_eq("rst_aluout_me", ALUouttoMe, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU result
    ex_op(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check_eq("add_exm_addr", ALUouttoMe, 32'h1234);
    check_eq("add_exm_rw", {27'b0, rwtoMe}, 32'd5);
    check_eq("add_stall", {31'b0, mem_stall}, 32'h0);
    check_eq("add_dm_req", {31'b0, dm_req}, 32'h0);
    @(negedge clk);
    check_eq("add_busW", busW, 32'h1234);
    check_eq("add_rwtoRe", {27'b0, rwtoRe}, 32'd5);
    check_eq("add_regwr_re", {31'b0, RegWrtoRe}, 32'h1);

    // lw with 3 wait cycles
    @(posedge clk); #1;
    ex_op(1'b1, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    bubble();
    mem_access(3, 32'hDEAD_BEEF, stalls);
    check_eq("lw_stalls", stalls, 32'd3);
    @(negedge clk);
    check_eq("lw_busW", busW, 32'hDEAD_BEEF);
    check_eq("lw_rwtoRe", {27'b0, rwtoRe}, 32'd7);
    check_eq("lw_regwr_re", {31'b0, RegWrtoRe}, 32'h1);
    check_eq("lw_err_bus", {31'b0, err_bus}, 32'h0);

    // sw zero-wait
    ex_op(1'b1, 32'h0000_0204, 32'h0000_55AA, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    @(posedge clk); #1;
    bubble();
    dm_ready = 1'b1;
    @(negedge clk);
    check_eq("sw_req", {31'b0, dm_req}, 32'h1);
    check_eq("sw_we", {31'b0, dm_we}, 32'h1);
    check_eq("sw_be", {28'b0, dm_be}, 32'hF);
    check_eq("sw_addr", dm_addr, 32'h204);
    check_eq("sw_wdata", dm_wdata, 32'h55AA);
    check_eq("sw_stall", {31'b0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dm_ready = 1'b0;

    // misaligned lw
    ex_op(1'b1, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check_eq("mis_req", {31'b0, dm_req}, 32'h0);
    check_eq("mis_stall", {31'b0, mem_stall}, 32'h0);
    @(negedge clk);
    check_eq("mis_err_align", {31'b0, err_align}, 32'h1);
    check_eq("mis_regwr_re", {31'b0, RegWrtoRe}, 32'h0);
    @(negedge clk);
    check_eq("mis_err_align_clr", {31'b0, err_align}, 32'h0);

    // lw that never gets ready -> abort after 16 stalled cycles
    @(posedge clk); #1;
    ex_op(1'b1, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    ex_op(1'b1, 32'h0000_0ABC, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    mem_access(1000, 32'h1111_2222, stalls);
    bubble();
    check_eq("to_stalls", stalls, 32'd16);
    @(negedge clk);
    check_eq("to_err_bus", {31'b0, err_bus}, 32'h1);
    check_eq("to_regwr_re", {31'b0, RegWrtoRe}, 32'h0);
    check_eq("to_next_in_exm", ALUouttoMe, 32'hABC);
    check_eq("to_idle_req", {31'b0, dm_req}, 32'h0);
    @(negedge clk);
    check_eq("to_next_busW", busW, 32'hABC);
    check_eq("to_next_regwr", {31'b0, RegWrtoRe}, 32'h1);
    check_eq("to_err_bus_clr", {31'b0, err_bus}, 32'h0);

`ifdef MEM_BYTE_EN
    // signed byte load from lane 3
    @(posedge clk); #1;
    ex_op(1'b1, 32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
    @(posedge clk); #1;
    bubble();
    dm_rdata = 32'h8012_3456;
    dm_ready = 1'b1;
    @(negedge clk);
    check_eq("lb_be", {28'b0, dm_be}, 32'h8);
    check_eq("lb_stall", {31'b0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dm_ready = 1'b0;
    @(negedge clk);
    check_eq("lb_busW", busW, 32'hFFFF_FF80);
    check_eq("lb_regwr_re", {31'b0, RegWrtoRe}, 32'h1);
`endif

    // reset asserted while waiting on memory
    @(posedge clk); #1;
    ex_op(1'b1, 32'h0000_0400, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    bubble();
    dm_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rw_req_before", {31'b0, dm_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rw_req_after", {31'b0, dm_req}, 32'h0);
    check_eq("rw_stall", {31'b0, mem_stall}, 32'h0);
    check_eq("rw_aluout_me", ALUouttoMe, 32'h0);
    check_eq("rw_rw_me", {27'b0, rwtoMe}, 32'h0);
    check_eq("rw_m2r_me", {31'b0, MentoRegtoMe}, 32'h0);
    check_eq("rw_busW", busW, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rw_idle_req", {31'b0, dm_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
